div_seq: RTL and testbench

- Multi-cycle 32-bit integer divide sequencer serving the execute stage.
- The execute stage raises start_i with latched operands and holds the pipeline while busy_o or a pending start is active.
- The block runs a restoring radix-2 division, one quotient bit per cycle.
- It returns {remainder, quotient} with a ready strobe, and supports signed/unsigned operation, divide-by-zero and annulment on pipeline flush.

---
 rtl/div_seq_if.sv | 36 +++
 rtl/div_seq.sv | 146 ++++++++++++++
 tb/tb_div_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle between the execute stage and the divide sequencer.
// The execute stage holds the master modport; the divider holds the slave modport.
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring radix-2 divider, one quotient bit per cycle, signed/unsigned.
// Result is {remainder, quotient}, held with ready until the execute stage drops start.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 signed_q, signed_d;
    logic                 sign1_q, sign1_d;
    logic                 sign2_q, sign2_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     diff;
    logic                 borrow;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;

    // quo_q starts out holding the dividend magnitude; its MSB feeds the partial
    // remainder while quotient bits shift in from the bottom.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        borrow  = diff[WIDTH+1];
    end

    always_comb begin
        quo_fix = (signed_q && (sign1_q != sign2_q)) ? -quo_q : quo_q;
        rem_fix = (signed_q && sign1_q) ? -rem_q : rem_q;
    end

    always_comb begin
        op1_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
        op2_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        signed_d = signed_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            StFree: begin
                ready_d  = 1'b0;
                result_d = '0;
                cnt_d    = '0;
                if (bus.start_i && !bus.annul_i) begin
                    signed_d = bus.signed_div_i;
                    sign1_d  = bus.opdata1_i[WIDTH-1];
                    sign2_d  = bus.opdata2_i[WIDTH-1];
                    quo_d    = op1_mag;
                    dvs_d    = op2_mag;
                    rem_d    = '0;
                    state_d  = (bus.opdata2_i == '0) ? StByZero : StOn;
                end
            end
            StByZero: begin
                state_d  = StEnd;
                result_d = '0;
                ready_d  = 1'b1;
            end
            StOn: begin
                if (bus.annul_i) begin
                    state_d = StFree;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else if (cnt_q != CntLast) begin
                    rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~borrow};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = StEnd;
                end
            end
            StEnd: begin
                if (!bus.start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = StFree;
        endcase

        busy_d = (state_d == StOn) || (state_d == StByZero);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            signed_q <= signed_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: stimulus pushes expected results into a queue,
// an independent monitor pops and compares each time ready_o rises.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result 0x%0h expected no result", bus.result_o);
            end else begin
                check("result", bus.result_o, exp_q.pop_front());
            end
        end
        prev_ready <= bus.ready_o;
    end

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int exp_lat,
                           input int hold, input logic scramble);
        int lat = 0;
        int busy_cnt = 0;
        @(posedge clk);
        #1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);  // edge 1 samples start
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.busy_o === 1'b1) busy_cnt++;
            if (scramble && k == 2) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~bus.signed_div_i;
            end
            if (bus.ready_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ready expected ready after edge %0d", name, exp_lat);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({name, "_busy_at_ready"}, 64'(bus.busy_o), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({name, "_hold_result"}, bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        check({name, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
        check({name, "_drop_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 1, 1'b0);
        run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 1, 1'b0);
        run_div("u_fff9_2", 32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 34, 1, 1'b0);
        run_div("u_div0", 32'h1234, 32'd0, 1'b0, 64'd0, 2, 1, 1'b0);
        run_div("s_div0", 32'h1234, 32'd0, 1'b1, 64'd0, 2, 1, 1'b0);
        run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, 1, 1'b0);

        // Annul at counter=10 (counter is edge-1, so after edge 11).
        @(posedge clk);
        #1;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 11; k++) @(negedge clk);
        check("annul_busy_before", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_busy_after", 64'(bus.busy_o), 64'd0);
        check("annul_ready_after", 64'(bus.ready_o), 64'd0);
        // start+annul while in FREE must be ignored
        @(negedge clk);
        check("annul_free_busy", 64'(bus.busy_o), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (3) @(negedge clk);
        check("annul_no_ready", 64'(bus.ready_o), 64'd0);

        run_div("u_ffff_1_scr", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 34, 1, 1'b1);

        // Asynchronous reset mid-division at counter=20.
        @(posedge clk);
        #1;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 21; k++) @(negedge clk);
        check("rst_mid_busy_before", 64'(bus.busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
        check("rst_mid_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_after_busy", 64'(bus.busy_o), 64'd0);
        check("rst_after_ready", 64'(bus.ready_o), 64'd0);

        run_div("u100_7_hold", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 5, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
